// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control sequencer.
//   state_t        : sequencer state encoding
//   instr_class_t  : instruction class latched at fetch
//   OP_*           : LEGv8 opcode constants (wildcard groups held as prefixes)
//   ALUSRC_*/ALUOP_*: ALU operand-select and operation encodings, also
//                    consumed by the ALU control block
//   alu_ctrl_for() : ALUSrc/ALUOp pair for a given instruction class
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP     = 4'd0,
        CLS_R       = 4'd1,
        CLS_I       = 4'd2,
        CLS_LD      = 4'd3,
        CLS_ST      = 4'd4,
        CLS_CBZ     = 4'd5,
        CLS_CBNZ    = 4'd6,
        CLS_UB      = 4'd7,
        CLS_HALT    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_class_t;

    // Fully specified opcodes.
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // Opcodes whose low bits are part of the immediate: only the prefix
    // is significant.
    localparam logic [9:0]  OP_ADDI_HI = 10'b1001000100;   // opcode[10:1]
    localparam logic [7:0]  OP_CBZ_HI  = 8'b10110100;      // opcode[10:3]
    localparam logic [7:0]  OP_CBNZ_HI = 8'b10110101;      // opcode[10:3]
    localparam logic [5:0]  OP_B_HI    = 6'b000101;        // opcode[10:5]

    localparam logic [1:0] ALUSRC_REG   = 2'b00;  // register operand
    localparam logic [1:0] ALUSRC_SEXT  = 2'b01;  // signExtInstr
    localparam logic [1:0] ALUSRC_IMM12 = 2'b10;  // Instruction[21:10]

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_PASSB  = 2'b01;  // CB-type: pass operand B
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;  // R-type funct decode

    typedef struct packed {
        logic [1:0] alu_src;
        logic [1:0] alu_op;
    } alu_ctrl_t;

    function automatic alu_ctrl_t alu_ctrl_for(input instr_class_t cls);
        alu_ctrl_t c;
        c.alu_src = ALUSRC_REG;
        c.alu_op  = ALUOP_ADD;
        case (cls)
            CLS_R: begin
                c.alu_src = ALUSRC_REG;
                c.alu_op  = ALUOP_FUNCT;
            end
            CLS_I: begin
                c.alu_src = ALUSRC_IMM12;
                c.alu_op  = ALUOP_FUNCT;
            end
            CLS_LD, CLS_ST: begin
                c.alu_src = ALUSRC_SEXT;
                c.alu_op  = ALUOP_ADD;
            end
            CLS_CBZ, CLS_CBNZ: begin
                c.alu_src = ALUSRC_REG;
                c.alu_op  = ALUOP_PASSB;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier.
//   opcode : Instruction[31:21]
//   cls    : instruction class; CLS_ILLEGAL for anything unrecognised.
// The halt opcode is checked first so it wins over any overlapping group.
module instr_class_decode
    import cpu_ctrl_pkg::*;
#(
    parameter logic [10:0] HALT_OPCODE = 11'b11111111111
) (
    input  logic [10:0]  opcode,
    output instr_class_t cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        if (opcode == HALT_OPCODE) begin
            cls = CLS_HALT;
        end else if (opcode == OP_ADD || opcode == OP_SUB ||
                     opcode == OP_AND || opcode == OP_ORR) begin
            cls = CLS_R;
        end else if (opcode[10:1] == OP_ADDI_HI) begin
            cls = CLS_I;
        end else if (opcode == OP_LDUR) begin
            cls = CLS_LD;
        end else if (opcode == OP_STUR) begin
            cls = CLS_ST;
        end else if (opcode[10:3] == OP_CBZ_HI) begin
            cls = CLS_CBZ;
        end else if (opcode[10:3] == OP_CBNZ_HI) begin
            cls = CLS_CBNZ;
        end else if (opcode[10:5] == OP_B_HI) begin
            cls = CLS_UB;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the LEGv8 core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB and drives
// the datapath controls as a Moore decode of (state, latched class).
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   run           : start request, sampled only in IDLE
//   opcode        : Instruction[31:21], valid with mem_ready in FETCH
//   mem_ready     : memory access completes this cycle
//   mem_req       : memory access request (fetch or data)
//   IRWrite       : load instruction register
//   PCWrite       : update PC
//   ALUSrc, ALUOp : ALU operand select / operation
//   B, BZ, BNZ    : branch-type qualifiers
//   MemRead, MemWrite, MemtoReg, RegWrite : datapath controls
//   busy, halted, fault : sequencer status
//   instr_count   : retired instruction count (wraps)
//
// Memory handshake: mem_req stays high for the whole FETCH or MEM state; the
// access completes in the cycle where mem_ready is sampled high while mem_req
// is high. If MEM_TIMEOUT consecutive request cycles pass without mem_ready
// the sequencer enters FAULT. IRWrite and the store's PCWrite are qualified by
// mem_ready so the IR and PC update exactly once per completed access.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int          COUNT_W     = 32,
    parameter int          MEM_TIMEOUT = 16,
    parameter logic [10:0] HALT_OPCODE = 11'b11111111111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [10:0]        opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         ALUSrc,
    output logic [1:0]         ALUOp,
    output logic               B,
    output logic               BZ,
    output logic               BNZ,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t       state;
    state_t       state_next;
    instr_class_t cls;
    instr_class_t dec_cls;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_next;
    logic          retire;
    logic          timeout;
    alu_ctrl_t     alu;

    instr_class_decode #(
        .HALT_OPCODE(HALT_OPCODE)
    ) u_decode (
        .opcode(opcode),
        .cls   (dec_cls)
    );

    assign alu = alu_ctrl_for(cls);

    // The counter holds the number of request cycles already spent without
    // mem_ready; the current cycle is the last allowed one when it reaches
    // MEM_TIMEOUT-1.
    assign timeout = (tcnt == TW'(MEM_TIMEOUT - 1));

    // State register, latched class, timeout counter and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cls         <= CLS_NOP;
            tcnt        <= '0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            tcnt  <= tcnt_next;
            if (state == ST_FETCH && mem_ready) begin
                cls <= dec_cls;
            end
            if (retire) begin
                instr_count <= instr_count + COUNT_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready)    state_next = ST_DECODE;
                else if (timeout) state_next = ST_FAULT;
            end
            ST_DECODE: begin
                case (cls)
                    CLS_HALT:             state_next = ST_HALT;
                    CLS_ILLEGAL, CLS_NOP: state_next = ST_FAULT;
                    default:              state_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (cls)
                    CLS_CBZ, CLS_CBNZ, CLS_UB: begin
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end
                    CLS_LD, CLS_ST: state_next = ST_MEM;
                    default:        state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (cls == CLS_ST) begin
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_WB: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            ST_HALT:  state_next = ST_HALT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_IDLE;
        endcase

        // Cleared on any state entry and on every completed access.
        if (state_next != state || mem_ready) begin
            tcnt_next = '0;
        end else if (state == ST_FETCH || state == ST_MEM) begin
            tcnt_next = tcnt + TW'(1);
        end else begin
            tcnt_next = '0;
        end
    end

    // Output decode.
    always_comb begin
        mem_req  = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        ALUSrc   = ALUSRC_REG;
        ALUOp    = ALUOP_ADD;
        B        = 1'b0;
        BZ       = 1'b0;
        BNZ      = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state)
            ST_FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                MemRead = 1'b1;
                IRWrite = mem_ready;
            end
            ST_DECODE: begin
                busy = 1'b1;
            end
            ST_EXEC: begin
                busy   = 1'b1;
                ALUSrc = alu.alu_src;
                ALUOp  = alu.alu_op;
                case (cls)
                    CLS_CBZ: begin
                        BZ      = 1'b1;
                        PCWrite = 1'b1;
                    end
                    CLS_CBNZ: begin
                        BNZ     = 1'b1;
                        PCWrite = 1'b1;
                    end
                    CLS_UB: begin
                        B       = 1'b1;
                        PCWrite = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                busy     = 1'b1;
                ALUSrc   = alu.alu_src;
                ALUOp    = alu.alu_op;
                mem_req  = 1'b1;
                MemRead  = (cls == CLS_LD);
                MemWrite = (cls == CLS_ST);
                PCWrite  = (cls == CLS_ST) && mem_ready;
            end
            ST_WB: begin
                busy     = 1'b1;
                ALUSrc   = alu.alu_src;
                ALUOp    = alu.alu_op;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                MemtoReg = (cls == CLS_LD);
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

endmodule
